// File: rtl/rfg_bank_pkg.sv
// rfg_bank_pkg: shared status layout and default address map for the RFG register bank
package rfg_bank_pkg;
  localparam logic [7:0] DEF_FIFO_ADDR = 8'h40;
  localparam logic [7:0] DEF_STATUS_ADDR = 8'h41;
  typedef struct packed {
    logic underflow;
    logic full;
    logic empty;
    logic [4:0] level;
  } status_t;
endpackage

// File: rtl/rfg_bank_sync_fifo.sv
// rfg_bank_sync_fifo: byte FIFO with registered data_out/full/empty/level; pop on empty yields 8'h00
module rfg_bank_sync_fifo #(
  parameter int AW = 4
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  logic [7:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] lvl_n;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign lvl_n = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge aclk)
    if (do_push) mem[wp] <= data_in;
  always_ff @(posedge aclk)
    if (areset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      data_out <= 8'h00;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      level <= lvl_n;
      full <= lvl_n == DEPTH;
      empty <= lvl_n == '0;
      data_out <= do_pop ? mem[rp] : 8'h00;
    end
endmodule

// File: rtl/rfg_register_bank.sv
// rfg_register_bank: RFG config registers, readout FIFO window and FIFO status register.
// Define RFG_BANK_ERRCNT_EN to add a saturating unmapped-access counter at STATUS_ADDR+1.
module rfg_register_bank
  import rfg_bank_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] REG_RESET   = 8'h00,
  parameter int         FIFO_AWIDTH = 4,
  parameter logic [7:0] FIFO_ADDR   = DEF_FIFO_ADDR,
  parameter logic [7:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [7:0]            rfg_address,
  input  logic [7:0]            rfg_write_value,
  input  logic                  rfg_write,
  input  logic                  rfg_write_last,
  input  logic                  rfg_read,
  output logic                  rfg_read_valid,
  output logic [7:0]            rfg_read_value,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic [NUM_REGS-1:0]   reg_write_pulse,
  output logic                  burst_done
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NR = 8'(NUM_REGS);
  logic [NUM_REGS-1:0][7:0] regs;
  logic [7:0] rd_val, rd_mux, fifo_dout, err_val;
  logic fifo_full, fifo_empty, underflow, is_reg, is_fifo, is_status, is_err;
  logic [FIFO_AWIDTH:0] fifo_level;
  logic [IW-1:0] ri;
  status_t st;
  assign ri = rfg_address[IW-1:0];
  assign is_reg = rfg_address < NR;
  assign is_fifo = rfg_address == FIFO_ADDR;
  assign is_status = rfg_address == STATUS_ADDR;
  assign st = '{underflow: underflow, full: fifo_full, empty: fifo_empty, level: 5'(fifo_level)};
  assign rd_mux = is_reg ? regs[ri] : is_status ? 8'(st) : is_err ? err_val : 8'h00;
  assign s_axis_tready = !fifo_full && !areset;
  assign regs_out = regs;
  // FIFO data is already zero unless a pop happened, so OR-ing merges the two read sources
  assign rfg_read_value = rd_val | fifo_dout;
  rfg_bank_sync_fifo #(.AW(FIFO_AWIDTH)) u_fifo (
    .aclk     (aclk),
    .areset   (areset),
    .push     (s_axis_tvalid && s_axis_tready),
    .pop      (rfg_read && is_fifo),
    .data_in  (s_axis_tdata),
    .data_out (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );
  always_ff @(posedge aclk)
    if (areset) begin
      regs <= {NUM_REGS{REG_RESET}};
      reg_write_pulse <= '0;
      burst_done <= 1'b0;
      underflow <= 1'b0;
      rfg_read_valid <= 1'b0;
      rd_val <= 8'h00;
    end else begin
      reg_write_pulse <= '0;
      if (rfg_write && is_reg) begin
        regs[ri] <= rfg_write_value;
        reg_write_pulse[ri] <= 1'b1;
      end
      burst_done <= rfg_write && rfg_write_last;
      underflow <= (rfg_read && is_fifo && fifo_empty) ||
                   (underflow && !(rfg_write && is_status && rfg_write_value[7]));
      rfg_read_valid <= rfg_read;
      rd_val <= rfg_read ? rd_mux : 8'h00;
    end
`ifdef RFG_BANK_ERRCNT_EN
  logic unmapped;
  logic [8:0] err_sum;
  assign is_err = rfg_address == STATUS_ADDR + 8'd1;
  assign unmapped = !(is_reg || is_fifo || is_status || is_err);
  assign err_sum = {1'b0, err_val} + 9'(rfg_read && unmapped) + 9'(rfg_write && unmapped);
  always_ff @(posedge aclk)
    if (areset) err_val <= 8'h00;
    else if (rfg_write && is_err) err_val <= 8'h00;
    else err_val <= err_sum[8] ? 8'hFF : err_sum[7:0];
`else
  assign is_err = 1'b0;
  assign err_val = 8'h00;
`endif
endmodule

// File: tb/tb_rfg_register_bank.sv
// tb_rfg_register_bank: directed scenarios plus randomized traffic against a queue-based reference model
module tb_rfg_register_bank;
  logic aclk = 0, areset = 1;
  logic [7:0] rfg_address = 0, rfg_write_value = 0, s_axis_tdata = 0, rfg_read_value;
  logic rfg_write = 0, rfg_write_last = 0, rfg_read = 0, s_axis_tvalid = 0;
  logic rfg_read_valid, s_axis_tready, burst_done;
  logic [127:0] regs_out;
  logic [15:0] reg_write_pulse;
  int checks = 0, errors = 0;

  logic [7:0] m_regs [16];
  logic [7:0] q [$];
  bit m_uf;
  bit exp_valid, exp_bd;
  logic [7:0] exp_rv;
  logic [15:0] exp_pulse;

  rfg_register_bank dut (
    .aclk(aclk), .areset(areset), .rfg_address(rfg_address), .rfg_write_value(rfg_write_value),
    .rfg_write(rfg_write), .rfg_write_last(rfg_write_last), .rfg_read(rfg_read),
    .rfg_read_valid(rfg_read_valid), .rfg_read_value(rfg_read_value), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .regs_out(regs_out),
    .reg_write_pulse(reg_write_pulse), .burst_done(burst_done)
  );

  always #5 aclk = ~aclk;

  function automatic void model_reset();
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    q.delete();
    m_uf = 0;
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i+:8] = m_regs[i];
    return f;
  endfunction

  function automatic void model_step(bit rd, bit wr, logic [7:0] a, logic [7:0] wv, bit last, bit tv, logic [7:0] td);
    bit pre_full = q.size() == 16;
    bit pre_empty = q.size() == 0;
    exp_valid = rd;
    exp_rv = 8'h00;
    exp_pulse = '0;
    exp_bd = wr && last;
    if (rd) begin
      if (a < 16) exp_rv = m_regs[a];
      else if (a == 8'h40) begin
        if (pre_empty) m_uf = 1;
        else exp_rv = q.pop_front();
      end else if (a == 8'h41) exp_rv = {m_uf, pre_full, pre_empty, 5'(q.size())};
    end
    if (wr) begin
      if (a < 16) begin
        m_regs[a] = wv;
        exp_pulse[a[3:0]] = 1'b1;
      end else if (a == 8'h41 && wv[7]) m_uf = 0;
    end
    if (tv && !pre_full) q.push_back(td);
  endfunction

  task automatic cyc(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wv,
                     input bit last, input bit tv, input logic [7:0] td);
    rfg_read = rd; rfg_write = wr; rfg_address = a; rfg_write_value = wv;
    rfg_write_last = last; s_axis_tvalid = tv; s_axis_tdata = td;
    if (!areset) model_step(rd, wr, a, wv, last, tv, td);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
    checks++; if (rfg_read_valid !== 1'b0 || rfg_read_value !== 8'h00) begin errors++; $display("FAIL reset_read got %b/%h want 0/00", rfg_read_valid, rfg_read_value); end
    checks++; if (regs_out !== '0 || reg_write_pulse !== '0 || burst_done !== 1'b0) begin errors++; $display("FAIL reset_regs got %h/%h/%b want 0", regs_out, reg_write_pulse, burst_done); end
    areset = 0;
    model_reset();
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b want 1", s_axis_tready); end
  endtask

  task automatic test_reg_rw();
    cyc(0, 1, 8'd3, 8'hA5, 0, 0, 0);
    checks++; if (regs_out[31:24] !== 8'hA5) begin errors++; $display("FAIL reg3_value got %h want a5", regs_out[31:24]); end
    checks++; if (reg_write_pulse !== 16'h0008) begin errors++; $display("FAIL reg3_pulse got %h want 0008", reg_write_pulse); end
    cyc(1, 0, 8'd3, 0, 0, 0, 0);
    checks++; if (reg_write_pulse !== 16'h0000) begin errors++; $display("FAIL reg3_pulse_width got %h want 0000", reg_write_pulse); end
    checks++; if (rfg_read_valid !== 1'b1 || rfg_read_value !== 8'hA5) begin errors++; $display("FAIL reg3_read got %b/%h want 1/a5", rfg_read_valid, rfg_read_value); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rfg_read_valid !== 1'b0) begin errors++; $display("FAIL read_valid_width got %b want 0", rfg_read_valid); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'(i), 8'(i + 1), i == 3, 0, 0);
      checks++; if (burst_done !== (i == 3)) begin errors++; $display("FAIL burst_done_%0d got %b want %b", i, burst_done, i == 3); end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL burst_done_width got %b want 0", burst_done); end
    checks++; if (regs_out[31:0] !== 32'h04030201) begin errors++; $display("FAIL burst_regs got %h want 04030201", regs_out[31:0]); end
  endtask

  task automatic test_fifo();
    logic [7:0] b [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, b[i]);
    cyc(1, 0, 8'h41, 0, 0, 0, 0);
    checks++; if (rfg_read_value !== 8'h03) begin errors++; $display("FAIL status_level3 got %h want 03", rfg_read_value); end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 8'h40, 0, 0, 0, 0);
      checks++; if (rfg_read_valid !== 1'b1 || rfg_read_value !== b[i]) begin errors++; $display("FAIL fifo_pop_%0d got %b/%h want 1/%h", i, rfg_read_valid, rfg_read_value, b[i]); end
    end
  endtask

  task automatic test_underflow();
    cyc(1, 0, 8'h40, 0, 0, 0, 0);
    checks++; if (rfg_read_valid !== 1'b1 || rfg_read_value !== 8'h00) begin errors++; $display("FAIL empty_pop got %b/%h want 1/00", rfg_read_valid, rfg_read_value); end
    cyc(1, 0, 8'h41, 0, 0, 0, 0);
    checks++; if (rfg_read_value !== 8'hA0) begin errors++; $display("FAIL status_underflow got %h want a0", rfg_read_value); end
    cyc(0, 1, 8'h41, 8'h80, 0, 0, 0);
    cyc(1, 0, 8'h41, 0, 0, 0, 0);
    checks++; if (rfg_read_value !== 8'h20) begin errors++; $display("FAIL status_cleared got %h want 20", rfg_read_value); end
  endtask

  task automatic test_full();
    logic [7:0] first = 8'($urandom);
    cyc(0, 0, 0, 0, 0, 1, first);
    for (int i = 1; i < 16; i++) cyc(0, 0, 0, 0, 0, 1, 8'($urandom));
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b want 0", s_axis_tready); end
    cyc(1, 0, 8'h41, 0, 0, 0, 0);
    checks++; if (rfg_read_value !== 8'h50) begin errors++; $display("FAIL status_full got %h want 50", rfg_read_value); end
    cyc(1, 0, 8'h40, 0, 0, 1, 8'hEE);
    checks++; if (rfg_read_value !== first || s_axis_tready !== 1'b1) begin errors++; $display("FAIL full_pop got %h/%b want %h/1", rfg_read_value, s_axis_tready, first); end
    cyc(0, 0, 0, 0, 0, 1, 8'hEE);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL refill_tready got %b want 0", s_axis_tready); end
    cyc(1, 0, 8'h41, 0, 0, 0, 0);
    checks++; if (rfg_read_value !== 8'h50) begin errors++; $display("FAIL status_refull got %h want 50", rfg_read_value); end
  endtask

  task automatic test_reset_mid();
    while (q.size() > 5) cyc(1, 0, 8'h40, 0, 0, 0, 0);
    cyc(0, 1, 8'd5, 8'h5A, 0, 0, 0);
    cyc(0, 1, 8'd6, 8'h6B, 0, 0, 0);
    areset = 1;
    cyc(1, 1, 8'd7, 8'h7C, 1, 1, 8'h99);
    checks++; if (regs_out !== '0 || reg_write_pulse !== '0 || burst_done !== 1'b0) begin errors++; $display("FAIL midreset_regs got %h/%h/%b want 0", regs_out, reg_write_pulse, burst_done); end
    checks++; if (rfg_read_valid !== 1'b0 || rfg_read_value !== 8'h00) begin errors++; $display("FAIL midreset_read got %b/%h want 0/00", rfg_read_valid, rfg_read_value); end
    areset = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (reg_write_pulse !== '0 || burst_done !== 1'b0 || rfg_read_valid !== 1'b0) begin errors++; $display("FAIL midreset_stray got %h/%b/%b want 0", reg_write_pulse, burst_done, rfg_read_valid); end
    cyc(1, 0, 8'h41, 0, 0, 0, 0);
    checks++; if (rfg_read_value !== 8'h20) begin errors++; $display("FAIL midreset_status got %h want 20", rfg_read_value); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int sel = $urandom_range(0, 9);
      logic [7:0] a = sel < 5 ? 8'($urandom_range(0, 15)) : sel < 7 || sel == 9 ? 8'h40 :
                      sel == 7 ? 8'h41 : 8'($urandom_range(128, 255));
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, a, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, 8'($urandom));
      checks++; if (rfg_read_valid !== exp_valid || (exp_valid && rfg_read_value !== exp_rv)) begin errors++; $display("FAIL rnd_read_%0d got %b/%h want %b/%h", n, rfg_read_valid, rfg_read_value, exp_valid, exp_rv); end
      checks++; if (regs_out !== m_flat() || reg_write_pulse !== exp_pulse || burst_done !== exp_bd) begin errors++; $display("FAIL rnd_regs_%0d got %h/%h/%b want %h/%h/%b", n, regs_out, reg_write_pulse, burst_done, m_flat(), exp_pulse, exp_bd); end
      checks++; if (s_axis_tready !== (q.size() < 16)) begin errors++; $display("FAIL rnd_tready_%0d got %b want %b", n, s_axis_tready, q.size() < 16); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_rw();
    test_burst();
    test_fifo();
    test_underflow();
    test_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
